// File: rtl/uart_pkg.sv
// Shared UART types and default baud divisors (16x tick at 36 MHz), common to the Rx and Tx paths.
package uart_pkg;

  typedef enum logic [1:0] {Baud48, Baud96, Baud192, Baud384} baud_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  localparam int unsigned DivW   = 10;
  localparam int unsigned Div48  = 469;
  localparam int unsigned Div96  = 234;
  localparam int unsigned Div192 = 117;
  localparam int unsigned Div384 = 59;

  function automatic logic [DivW-1:0] baud_div(baud_e baud);
    logic [DivW-1:0] div;
    unique case (baud)
      Baud48:  div = DivW'(Div48);
      Baud96:  div = DivW'(Div96);
      Baud192: div = DivW'(Div192);
      Baud384: div = DivW'(Div384);
      default: div = DivW'(Div96);
    endcase
    return div;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and baud select in, received byte and status out.
interface uart_rx_if;
  import uart_pkg::*;

  baud_e      baud_rate;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (
    input  baud_rate,
    input  rx,
    output data_out,
    output data_valid,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    output baud_rate,
    output rx,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  parity_err,
    input  busy
  );

endinterface

// File: rtl/uart_rx_tick_gen.sv
// 16x oversampling prescaler: one-cycle tick every div_i clocks, restartable via clr_i.
module uart_rx_tick_gen
  import uart_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            clr_i,
  input  logic [DivW-1:0] div_i,
  output logic            tick_o
);

  logic [DivW-1:0] cnt_d, cnt_q;
  logic            at_top;

  assign at_top = (cnt_q == (div_i - DivW'(1)));
  assign tick_o = at_top & ~clr_i;

  always_comb begin
    cnt_d = cnt_q + DivW'(1);
    if (clr_i || at_top) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, start-edge re-phased, optional parity, framing/parity error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned DIV48      = 469,
  parameter int unsigned DIV96      = 234,
  parameter int unsigned DIV192     = 117,
  parameter int unsigned DIV384     = 59
) (
  input logic      clk,
  input logic      resetn,
  uart_rx_if.master bus
);

  rx_state_e       state_d, state_q;
  baud_e           baud_d, baud_q;
  logic            rx_meta_q, rx_s_q, rx_prev_q;
  logic [3:0]      os_d, os_q;
  logic [2:0]      bit_cnt_d, bit_cnt_q;
  logic [7:0]      shift_d, shift_q;
  logic            par_bit_d, par_bit_q;
  logic [7:0]      data_out_d, data_out_q;
  logic            valid_d, valid_q;
  logic            frame_err_d, frame_err_q;
  logic            parity_err_d, parity_err_q;
  logic            busy_d, busy_q;
  logic [DivW-1:0] div;
  logic            fall, clr, tick, centre;

  assign fall   = rx_prev_q & ~rx_s_q;
  assign clr    = (state_q == StIdle) & fall;
  assign centre = tick & (os_q == 4'd15);

  always_comb begin
    unique case (baud_q)
      Baud48:  div = DivW'(DIV48);
      Baud96:  div = DivW'(DIV96);
      Baud192: div = DivW'(DIV192);
      Baud384: div = DivW'(DIV384);
      default: div = DivW'(DIV96);
    endcase
  end

  uart_rx_tick_gen u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .clr_i  (clr),
    .div_i  (div),
    .tick_o (tick)
  );

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    os_d         = tick ? os_q + 4'd1 : os_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    data_out_d   = data_out_q;
    valid_d      = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          baud_d  = bus.baud_rate;
          os_d    = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        // Line back high at mid-start: treat as a glitch, not a frame.
        if (tick && os_q == 4'd7) begin
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            os_d      = '0;
            bit_cnt_d = '0;
            state_d   = StData;
          end
        end
      end
      StData: begin
        if (centre) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY_EN ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (centre) begin
          par_bit_d = rx_s_q;
          state_d   = StStop;
        end
      end
      StStop: begin
        // Leave at mid-stop so a following start edge is not missed.
        if (centre) begin
          data_out_d   = shift_q;
          frame_err_d  = ~rx_s_q;
          parity_err_d = PARITY_EN && ((^shift_q ^ PARITY_ODD) != par_bit_q);
          valid_d      = 1'b1;
          state_d      = rx_s_q ? StIdle : StBreak;
        end
      end
      StBreak: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= StIdle;
      baud_q       <= Baud48;
      os_q         <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_meta_q    <= bus.rx;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      state_q      <= state_d;
      baud_q       <= baud_d;
      os_q         <= os_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      data_out_q   <= data_out_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.busy       = busy_q;

endmodule
